// File: rtl/compute_ctrl_if.sv
// Handshake and memory/MAC bus between compute_ctrl and its surroundings.
// The master side is the controller; the slave side is memories, MAC and the host.
interface compute_ctrl_if #(
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9,
  parameter int unsigned MAXK = 8
) ();
  localparam int unsigned K_BITS      = $clog2(MAXK + 1);
  localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK);
  localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N);

  logic                   matrices_loaded;
  logic [K_BITS-1:0]      K;
  logic                   compute_finished;
  logic [A_ADDR_BITS-1:0] A_read_addr;
  logic [B_ADDR_BITS-1:0] B_read_addr;
  logic                   out_ready;
  logic                   mac_valid;
  logic                   mac_init;
  logic                   mac_last;
  logic                   busy;

  modport master (
    input  matrices_loaded, K, out_ready,
    output compute_finished, A_read_addr, B_read_addr, mac_valid, mac_init, mac_last, busy
  );

  modport slave (
    output matrices_loaded, K, out_ready,
    input  compute_finished, A_read_addr, B_read_addr, mac_valid, mac_init, mac_last, busy
  );
endinterface

// File: rtl/compute_ctrl.sv
// Matrix-multiply sequencer: walks C = A*B row-major, issuing one A/B read per cycle to a MAC.
// Optional busy-cycle performance counter enabled by defining COMPUTE_CTRL_PERF_EN.
module compute_ctrl #(
  parameter int unsigned M    = 7,
  parameter int unsigned N    = 9,
  parameter int unsigned MAXK = 8
) (
  input  logic           clk,
  input  logic           reset,
  compute_ctrl_if.master bus
`ifdef COMPUTE_CTRL_PERF_EN
  ,
  output logic [31:0]    busy_cycles
`endif
);
  localparam int unsigned K_BITS      = $clog2(MAXK + 1);
  localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK);
  localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N);
  localparam int unsigned M_BITS      = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned N_BITS      = (N > 1) ? $clog2(N) : 1;
  localparam logic [M_BITS-1:0]      M_LAST = M_BITS'(M - 1);
  localparam logic [N_BITS-1:0]      N_LAST = N_BITS'(N - 1);
  localparam logic [B_ADDR_BITS-1:0] N_STEP = B_ADDR_BITS'(N);

  typedef enum logic [2:0] {
    StIdle, StWaitOut, StIssue, StDrain, StDone, StWaitClr
  } state_t;

  state_t                 state_q, state_d;
  logic [K_BITS-1:0]      k_lat_q, k_lat_d;
  logic [M_BITS-1:0]      m_q, m_d;
  logic [N_BITS-1:0]      n_q, n_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [A_ADDR_BITS-1:0] a_row_q, a_row_d;
  logic [A_ADDR_BITS-1:0] a_addr_q, a_addr_d;
  logic [B_ADDR_BITS-1:0] b_addr_q, b_addr_d;
  logic                   mac_valid_q, mac_valid_d;
  logic                   mac_init_q, mac_init_d;
  logic                   mac_last_q, mac_last_d;
  logic                   issue, k_last, row_end;
  logic [A_ADDR_BITS-1:0] k_step;

  always_comb begin
    state_d  = state_q;
    k_lat_d  = k_lat_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    issue    = (state_q == StIssue);
    k_last   = (k_q == k_lat_q - K_BITS'(1));
    row_end  = (n_q == N_LAST);
    k_step   = A_ADDR_BITS'(k_lat_q);

    case (state_q)
      StIdle: begin
        if (bus.matrices_loaded) begin
          if (bus.K != '0) begin
            k_lat_d  = bus.K;
            m_d      = '0;
            n_d      = '0;
            k_d      = '0;
            a_row_d  = '0;
            a_addr_d = '0;
            b_addr_d = '0;
            state_d  = StWaitOut;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWaitOut: begin
        if (bus.out_ready) state_d = StIssue;
      end
      StIssue: begin
        if (!k_last) begin
          k_d      = k_q + K_BITS'(1);
          a_addr_d = a_addr_q + A_ADDR_BITS'(1);
          b_addr_d = b_addr_q + N_STEP;
        end else begin
          // End of a dot product: rewind k, step to the next C element.
          k_d = '0;
          if (row_end) begin
            n_d      = '0;
            b_addr_d = '0;
            if (m_q == M_LAST) begin
              m_d      = '0;
              a_row_d  = '0;
              a_addr_d = '0;
            end else begin
              m_d      = m_q + M_BITS'(1);
              a_row_d  = a_row_q + k_step;
              a_addr_d = a_row_q + k_step;
            end
          end else begin
            n_d      = n_q + N_BITS'(1);
            b_addr_d = B_ADDR_BITS'(n_q) + B_ADDR_BITS'(1);
            a_addr_d = a_row_q;
          end
          if (row_end && (m_q == M_LAST)) state_d = StDrain;
          else if (bus.out_ready)         state_d = StIssue;
          else                            state_d = StWaitOut;
        end
      end
      StDrain:   state_d = StDone;
      StDone:    state_d = StWaitClr;
      StWaitClr: begin
        if (!bus.matrices_loaded) state_d = StIdle;
      end
      default:   state_d = StIdle;
    endcase

    // Read latency is one cycle, so MAC strobes trail the issue cycle.
    mac_valid_d = issue;
    mac_init_d  = issue && (k_q == '0);
    mac_last_d  = issue && k_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      k_lat_q     <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      a_row_q     <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      mac_valid_q <= 1'b0;
      mac_init_q  <= 1'b0;
      mac_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_lat_q     <= k_lat_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      a_row_q     <= a_row_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      mac_valid_q <= mac_valid_d;
      mac_init_q  <= mac_init_d;
      mac_last_q  <= mac_last_d;
    end
  end

  assign bus.A_read_addr      = a_addr_q;
  assign bus.B_read_addr      = b_addr_q;
  assign bus.mac_valid        = mac_valid_q;
  assign bus.mac_init         = mac_init_q;
  assign bus.mac_last         = mac_last_q;
  assign bus.compute_finished = (state_q == StDone);
  assign bus.busy             = (state_q != StIdle);

`ifdef COMPUTE_CTRL_PERF_EN
  logic [31:0] busy_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cycles_q <= '0;
    end else if ((state_q == StIdle) && bus.matrices_loaded) begin
      busy_cycles_q <= '0;
    end else if ((state_q != StIdle) && (busy_cycles_q != '1)) begin
      busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end

  assign busy_cycles = busy_cycles_q;
`endif
endmodule
